// File: rtl/booth_mul_seq_pkg.sv
// Shared constants for the iterative radix-4 Booth multiplier: FSM encodings,
// iteration count, Booth digit codes and the 64->68 bit extension helper.
package booth_mul_seq_pkg;

    localparam int NSTEP = 17;
    localparam int CNT_W = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Booth window {b[2i+1], b[2i], b[2i-1]}
    localparam logic [2:0] BC_ZERO_P = 3'b000;
    localparam logic [2:0] BC_P1_A   = 3'b001;
    localparam logic [2:0] BC_P1_B   = 3'b010;
    localparam logic [2:0] BC_P2     = 3'b011;
    localparam logic [2:0] BC_M2     = 3'b100;
    localparam logic [2:0] BC_M1_A   = 3'b101;
    localparam logic [2:0] BC_M1_B   = 3'b110;
    localparam logic [2:0] BC_ZERO_N = 3'b111;

    function automatic logic [67:0] ext68(input logic [63:0] v, input logic sgn);
        return sgn ? {{4{v[63]}}, v} : {4'b0000, v};
    endfunction

endpackage

// File: rtl/mul_dec.sv
// Combinational radix-4 Booth selector. Negative digits return the one's
// complement in parttmp_o and set rest_o so the adder supplies the +1.
module mul_dec
    import booth_mul_seq_pkg::*;
(
    input  logic [2:0]  code_i,
    input  logic [33:0] aman_i,
    output logic [34:0] parttmp_o,
    output logic        rest_o
);

    // Select 0, +-A or +-2A in a 35-bit two's complement field
    always_comb begin
        parttmp_o = 35'd0;
        rest_o    = 1'b0;
        case (code_i)
            BC_P1_A, BC_P1_B: begin
                parttmp_o = {aman_i[33], aman_i};
                rest_o    = 1'b0;
            end
            BC_P2: begin
                parttmp_o = {aman_i, 1'b0};
                rest_o    = 1'b0;
            end
            BC_M2: begin
                parttmp_o = ~{aman_i, 1'b0};
                rest_o    = 1'b1;
            end
            BC_M1_A, BC_M1_B: begin
                parttmp_o = ~{aman_i[33], aman_i};
                rest_o    = 1'b1;
            end
            default: begin
                parttmp_o = 35'd0;
                rest_o    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier/accumulator for the ARM multiply path:
// one load cycle, 17 fixed iterations, then a one-cycle done pulse.
module booth_mul_seq
    import booth_mul_seq_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        signed_op,
    input  logic        acc_en,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic [63:0] acc_in,
    output logic        busy,
    output logic        done,
    output logic [63:0] result,
    output logic        res_n,
    output logic        res_z
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [33:0]      aman_q, aman_d;
    logic [33:0]      b_q, b_d;
    logic             bm1_q, bm1_d;
    logic [67:0]      acc_q, acc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [63:0]      result_q, result_d;
    logic             res_n_q, res_n_d;
    logic             res_z_q, res_z_d;

    logic             accept_s;
    logic             last_s;
    logic [2:0]       code_s;
    logic [34:0]      parttmp_s;
    logic             rest_s;
    logic [67:0]      pp_s;
    logic [67:0]      sum_s;

    assign accept_s = start && !busy_q;
    assign last_s   = (cnt_q == CNT_W'(NSTEP - 1));
    assign code_s   = {b_q[1:0], bm1_q};

    mul_dec u_mul_dec (
        .code_i    (code_s),
        .aman_i    (aman_q),
        .parttmp_o (parttmp_s),
        .rest_o    (rest_s)
    );

    // Partial product weighted by 4^i; the multiplier window shifts instead of the multiplicand
    assign pp_s  = {{33{parttmp_s[34]}}, parttmp_s} + {67'd0, rest_s};
    assign sum_s = acc_q + (pp_s << {cnt_q, 1'b0});

    // Next-state logic for the FSM, counter, operands and accumulator
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        aman_d   = aman_q;
        b_d      = b_q;
        bm1_d    = bm1_q;
        acc_d    = acc_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        res_n_d  = res_n_q;
        res_z_d  = res_z_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    cnt_d   = {CNT_W{1'b0}};
                    aman_d  = signed_op ? {opa[31], opa[31], opa} : {2'b00, opa};
                    b_d     = signed_op ? {opb[31], opb[31], opb} : {2'b00, opb};
                    bm1_d   = 1'b0;
                    acc_d   = acc_en ? ext68(acc_in, signed_op) : 68'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d = sum_s;
                b_d   = {2'b00, b_q[33:2]};
                bm1_d = b_q[1];
                if (last_s) begin
                    state_d  = ST_DONE;
                    cnt_d    = {CNT_W{1'b0}};
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = sum_s[63:0];
                    res_n_d  = sum_s[63];
                    res_z_d  = (sum_s[63:0] == 64'd0);
                end else begin
                    state_d = ST_RUN;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset; reset also aborts a running operation
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            aman_q   <= 34'd0;
            b_q      <= 34'd0;
            bm1_q    <= 1'b0;
            acc_q    <= 68'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 64'd0;
            res_n_q  <= 1'b0;
            res_z_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            aman_q   <= aman_d;
            b_q      <= b_d;
            bm1_q    <= bm1_d;
            acc_q    <= acc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            res_n_q  <= res_n_d;
            res_z_q  <= res_z_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign res_n  = res_n_q;
    assign res_z  = res_z_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed-vector and random-model bench for booth_mul_seq. Latency counts the
// accepting edge as clock 1, so done is expected after clock 18.
module tb_booth_mul_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        signed_op;
    logic        acc_en;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [63:0] acc_in;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        res_n;
    logic        res_z;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        s;
        logic        ae;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] acc;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[15];

    always #5 clock = ~clock;

    booth_mul_seq dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .signed_op (signed_op),
        .acc_en    (acc_en),
        .opa       (opa),
        .opb       (opb),
        .acc_in    (acc_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .res_n     (res_n),
        .res_z     (res_z)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present operands, let the next edge accept them, then scramble the inputs
    task automatic start_op(input logic s, input logic ae, input logic [31:0] a,
                            input logic [31:0] b, input logic [63:0] acc);
        @(negedge clock);
        signed_op = s;
        acc_en    = ae;
        opa       = a;
        opb       = b;
        acc_in    = acc;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start     = 1'b0;
        opa       = $urandom;
        opb       = $urandom;
        acc_in    = {$urandom, $urandom};
        signed_op = ~s;
        acc_en    = ~ae;
    endtask

    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (done !== 1'b1 && lat < 60) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic do_op(input string name, input logic s, input logic ae,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] acc, input logic [63:0] exp);
        int lat;
        start_op(s, ae, a, b, acc);
        check({name, "_busy"}, 64'(busy), 64'd1);
        wait_done(1, lat);
        check({name, "_latency"}, 64'(lat), 64'd18);
        check({name, "_result"}, result, exp);
        check({name, "_res_n"}, 64'(res_n), 64'(exp[63]));
        check({name, "_res_z"}, 64'(res_z), 64'(exp == 64'd0));
        @(posedge clock);
        #1;
        check({name, "_done_pulse"}, 64'(done), 64'd0);
        check({name, "_held"}, result, exp);
    endtask

    function automatic logic [63:0] model(input logic s, input logic ae, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] acc);
        logic [63:0] xa;
        logic [63:0] xb;
        xa = s ? {{32{a[31]}}, a} : {32'h0, a};
        xb = s ? {{32{b[31]}}, b} : {32'h0, b};
        return xa * xb + (ae ? acc : 64'h0);
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h5555_5555;
            1:       return 32'hAAAA_AAAA;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat;
        int lat2;
        logic seen;
        logic        rs, rae;
        logic [31:0] ra, rb;
        logic [63:0] racc;

        vecs[0]  = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0, 64'hFFFF_FFFE_0000_0001};
        vecs[1]  = '{1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 64'h0, 64'h4000_0000_0000_0000};
        vecs[2]  = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0, 64'h0000_0000_0000_0001};
        vecs[3]  = '{1'b1, 1'b1, 32'h0000_0003, 32'hFFFF_FFFB, 64'd100, 64'h0000_0000_0000_0055};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0003, 32'hFFFF_FFFB, 64'd100, 64'hFFFF_FFFF_FFFF_FFF1};
        vecs[5]  = '{1'b0, 1'b0, 32'h0000_0005, 32'h0000_0007, 64'h0, 64'h0000_0000_0000_0023};
        vecs[6]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 64'h0, 64'h0};
        vecs[7]  = '{1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h0, 64'h3FFF_FFFF_0000_0001};
        vecs[8]  = '{1'b0, 1'b0, 32'h5555_5555, 32'h0000_0003, 64'h0, 64'h0000_0000_FFFF_FFFF};
        vecs[9]  = '{1'b0, 1'b0, 32'hAAAA_AAAA, 32'h0000_0002, 64'h0, 64'h0000_0001_5555_5554};
        vecs[10] = '{1'b1, 1'b0, 32'hAAAA_AAAA, 32'h0000_0001, 64'h0, 64'hFFFF_FFFF_AAAA_AAAA};
        vecs[11] = '{1'b0, 1'b1, 32'h0000_0002, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5};
        vecs[12] = '{1'b1, 1'b0, 32'h5555_5555, 32'hFFFF_FFFF, 64'h0, 64'hFFFF_FFFF_AAAA_AAAB};
        vecs[13] = '{1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 64'h0, 64'h4000_0000_0000_0000};
        vecs[14] = '{1'b1, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 64'h0, 64'hC000_0000_8000_0000};

        reset = 1'b1;
        start = 1'b0;
        signed_op = 1'b0;
        acc_en = 1'b0;
        opa = 32'h0;
        opb = 32'h0;
        acc_in = 64'h0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_res_n", 64'(res_n), 64'd0);
        check("rst_res_z", 64'(res_z), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].ae, vecs[i].a, vecs[i].b,
                  vecs[i].acc, vecs[i].exp);
        end

        // start pulsed during iteration 4 must be ignored
        start_op(1'b0, 1'b0, 32'd5, 32'd7, 64'h0);
        repeat (4) begin
            @(posedge clock);
            #1;
        end
        signed_op = 1'b1;
        opa = 32'd9;
        opb = 32'd9;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("ign_busy", 64'(busy), 64'd1);
        wait_done(6, lat);
        check("ign_latency", 64'(lat), 64'd18);
        check("ign_result", result, 64'd35);

        // reset at iteration 8 aborts without a done pulse
        @(posedge clock);
        #1;
        start_op(1'b0, 1'b0, 32'd5, 32'd7, 64'h0);
        repeat (7) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_result", result, 64'd0);
        check("abort_done", 64'(done), 64'd0);
        reset = 1'b0;
        seen = 1'b0;
        repeat (25) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) seen = 1'b1;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        do_op("zero", 1'b0, 1'b0, 32'h0, 32'h0, 64'h0, 64'h0);

        // back-to-back: second start arrives in the DONE cycle
        start_op(1'b0, 1'b0, 32'h0000_1234, 32'h0000_0010, 64'h0);
        wait_done(1, lat);
        check("b2b_first_latency", 64'(lat), 64'd18);
        check("b2b_first_result", result, 64'h0000_0000_0001_2340);
        start_op(1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_0003, 64'h0);
        check("b2b_busy", 64'(busy), 64'd1);
        check("b2b_done_fall", 64'(done), 64'd0);
        wait_done(1, lat2);
        check("b2b_done_to_done", 64'(lat2), 64'd18);
        check("b2b_second_result", result, 64'hFFFF_FFFF_FFFF_FFFA);
        @(posedge clock);
        #1;

        for (int k = 0; k < 1500; k++) begin
            rs   = 1'($urandom_range(0, 1));
            rae  = 1'($urandom_range(0, 1));
            ra   = pick();
            rb   = pick();
            racc = {pick(), pick()};
            start_op(rs, rae, ra, rb, racc);
            wait_done(1, lat);
            check($sformatf("rnd%0d_latency", k), 64'(lat), 64'd18);
            check($sformatf("rnd%0d_result", k), result, model(rs, rae, ra, rb, racc));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
